// File: rtl/ae_buffer_write.sv
// Write-side front end of the AE sample buffer: packs 4-bit samples eight to a
// 32-bit word and writes them to consecutive SRAM word addresses from 0.
module ae_buffer_write #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  fill_start,
    input  logic                  fill_abort,
    input  logic                  trig_mode,
    input  logic                  fill_trigger,
    input  logic [ADDR_WIDTH:0]   fill_words,
    input  logic [3:0]            sample_in,
    input  logic                  sample_in_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH:0]   words_written
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        FILL      = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   target_q, target_d;
    logic [ADDR_WIDTH:0]   words_written_q, words_written_d;
    logic [2:0]            nib_q, nib_d;
    logic [31:0]           pack_q, pack_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic take;
    logic last_written;
    logic clamp;

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        words_written_d = words_written_q;
        nib_d           = nib_q;
        pack_d          = pack_q;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        done_d          = 1'b0;
        take            = 1'b0;

        clamp        = (fill_words == '0) || (fill_words > DEPTH);
        // The final write has landed once the committed count reaches the target;
        // the block lingers in FILL for that one cycle so fill_done follows mem_we.
        last_written = (state_q == FILL) && (words_written_q == target_q);

        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    target_d        = clamp ? DEPTH : fill_words;
                    words_written_d = '0;
                    nib_d           = '0;
                    pack_d          = '0;
                    state_d         = trig_mode ? WAIT_TRIG : FILL;
                end
            end
            WAIT_TRIG: begin
                if (fill_trigger) begin
                    state_d = FILL;
                    take    = sample_in_valid;
                end
            end
            FILL: begin
                if (last_written) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    take = sample_in_valid;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            pack_d = {pack_q[27:0], sample_in};
            nib_d  = nib_q + 3'd1;
            if (nib_q == 3'd7) begin
                mem_we_d        = 1'b1;
                mem_addr_d      = words_written_q[ADDR_WIDTH-1:0];
                mem_wdata_d     = pack_d;
                words_written_d = words_written_q + 1'b1;
            end
        end

        // Abort overrides everything decided above, including a completing word.
        if (fill_abort) begin
            state_d         = IDLE;
            target_d        = target_q;
            words_written_d = words_written_q;
            nib_d           = '0;
            pack_d          = pack_q;
            mem_we_d        = 1'b0;
            mem_addr_d      = mem_addr_q;
            mem_wdata_d     = mem_wdata_q;
            done_d          = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q         <= IDLE;
            target_q        <= '0;
            words_written_q <= '0;
            nib_q           <= '0;
            pack_q          <= '0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            words_written_q <= words_written_d;
            nib_q           <= nib_d;
            pack_q          <= pack_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign fill_busy     = busy_q;
    assign fill_done     = done_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_ae_buffer_write.sv
// Bench for ae_buffer_write: per-cycle stimulus tables checked against a
// sample-stream model that groups accepted samples into words.
module tb_ae_buffer_write;
    localparam int AW   = 4;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          fill_start, fill_abort, trig_mode, fill_trigger;
    logic [AW:0]   fill_words;
    logic [3:0]    sample_in;
    logic          sample_in_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          fill_busy, fill_done;
    logic [AW:0]   words_written;

    ae_buffer_write #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_b(rst_b), .fill_start(fill_start), .fill_abort(fill_abort),
        .trig_mode(trig_mode), .fill_trigger(fill_trigger), .fill_words(fill_words),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fill_busy(fill_busy),
        .fill_done(fill_done), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0]  smp [MAXC];
    logic        vld [MAXC];
    int          trig_cyc, abort_cyc, restart_cyc;
    int          obs_n;
    logic [31:0] obs_data [64];

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            vld[c] = 1'b0;
            smp[c] = 4'h0;
        end
        trig_cyc = -1; abort_cyc = -1; restart_cyc = -1;
    endtask

    task automatic idle_inputs();
        fill_start = 0; fill_abort = 0; trig_mode = 0; fill_trigger = 0;
        fill_words = '0; sample_in = '0; sample_in_valid = 0;
    endtask

    // Cycle 0 carries fill_start; outputs sampled after edge c belong to cycle c+1.
    // ncyc == 0 runs exactly up to the predicted fill_done cycle.
    task automatic run_fill(input logic tm, input logic [AW:0] fw, input int ncyc, input string nm);
        int target, cb, cnt, nw, done_c, end_c, n, o, ew, wj;
        int wc [64];
        logic [31:0] wd [64];
        logic [31:0] acc;
        target = (fw == 0 || int'(fw) > (1 << AW)) ? (1 << AW) : int'(fw);
        cb = tm ? trig_cyc : 1;
        nw = 0; cnt = 0; acc = '0; done_c = -1; end_c = 1 << 30;
        for (int c = 1; c < MAXC; c++) begin
            if (c == abort_cyc) begin end_c = c + 1; break; end
            if (cb >= 1 && c >= cb && vld[c]) begin
                acc = {acc[27:0], smp[c]};
                cnt++;
                if (cnt % 8 == 0) begin
                    wc[nw] = c + 1; wd[nw] = acc; nw++;
                    if (nw == target) begin done_c = c + 2; end_c = done_c; break; end
                end
            end
        end
        n = (ncyc == 0) ? done_c : ncyc;
        if (n < 1 || n >= MAXC) begin
            checks++; failures++;
            $display("FAIL %s run_length got=%0d required=1..%0d", nm, n, MAXC - 1);
            n = MAXC - 1;
        end
        obs_n = 0;
        for (int c = 0; c < n; c++) begin
            fill_start      = (c == 0) || (c == restart_cyc);
            trig_mode       = tm;
            fill_words      = (c == 0) ? fw : 5'd3;
            fill_trigger    = (c == trig_cyc);
            fill_abort      = (c == abort_cyc);
            sample_in_valid = vld[c];
            sample_in       = smp[c];
            @(posedge clk);
            #1;
            o = c + 1;
            wj = -1; ew = 0;
            for (int j = 0; j < nw; j++) begin
                if (wc[j] == o) wj = j;
                if (wc[j] <= o) ew++;
            end
            checks++;
            if (mem_we !== (wj >= 0)) begin
                failures++;
                $display("FAIL %s mem_we cyc=%0d got=%0b required=%0b", nm, o, mem_we, wj >= 0);
            end
            if (mem_we === 1'b1) begin
                if (obs_n < 64) obs_data[obs_n] = mem_wdata;
                obs_n++;
            end
            if (wj >= 0) begin
                checks++;
                if (mem_addr !== AW'(wj) || mem_wdata !== wd[wj]) begin
                    failures++;
                    $display("FAIL %s write cyc=%0d got=%0d:%08h required=%0d:%08h",
                             nm, o, mem_addr, mem_wdata, wj, wd[wj]);
                end
            end
            checks++;
            if (fill_busy !== (o < end_c)) begin
                failures++;
                $display("FAIL %s fill_busy cyc=%0d got=%0b required=%0b", nm, o, fill_busy, o < end_c);
            end
            checks++;
            if (fill_done !== (o == done_c)) begin
                failures++;
                $display("FAIL %s fill_done cyc=%0d got=%0b required=%0b", nm, o, fill_done, o == done_c);
            end
            checks++;
            if (words_written !== (AW + 1)'(ew)) begin
                failures++;
                $display("FAIL %s words_written cyc=%0d got=%0d required=%0d", nm, o, words_written, ew);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_b = 1'b0;
        #12;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, fill_busy, fill_done, words_written} !== '0) begin
            failures++;
            $display("FAIL reset outputs got=%0b/%0h/%08h/%0b/%0b/%0d required=all zero",
                     mem_we, mem_addr, mem_wdata, fill_busy, fill_done, words_written);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_immediate();
        clear_stim();
        vld[0] = 1; smp[0] = 4'hF;
        for (int i = 0; i < 16; i++) begin
            vld[i + 1] = 1; smp[i + 1] = 4'((i + 1) % 16);
        end
        run_fill(1'b0, 5'd2, 22, "immediate");
        checks++;
        if (obs_n != 2 || obs_data[0] !== 32'h12345678 || obs_data[1] !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL immediate words got=%0d:%08h,%08h required=2:12345678,9abcdef0",
                     obs_n, obs_data[0], obs_data[1]);
        end
    endtask

    task automatic test_gapped();
        clear_stim();
        for (int i = 0; i < 8; i++) begin
            vld[3 * (i + 1)] = 1; smp[3 * (i + 1)] = 4'(8 + i);
        end
        run_fill(1'b0, 5'd1, 30, "gapped");
        checks++;
        if (obs_n != 1 || obs_data[0] !== 32'h89ABCDEF) begin
            failures++;
            $display("FAIL gapped word got=%0d:%08h required=1:89abcdef", obs_n, obs_data[0]);
        end
    endtask

    task automatic test_trigger();
        clear_stim();
        for (int c = 0; c < 60; c++) begin
            vld[c] = 1; smp[c] = (c <= 20) ? 4'hA : 4'h3;
        end
        trig_cyc = 21;
        run_fill(1'b1, 5'd1, 0, "trigger");
        checks++;
        if (obs_n != 1 || obs_data[0] !== 32'h33333333) begin
            failures++;
            $display("FAIL trigger word got=%0d:%08h required=1:33333333", obs_n, obs_data[0]);
        end
    endtask

    task automatic test_full_depth();
        clear_stim();
        for (int c = 0; c < 145; c++) begin
            vld[c] = 1; smp[c] = 4'($urandom_range(0, 15));
        end
        run_fill(1'b0, 5'd0, 140, "full_depth");
        clear_stim();
        for (int c = 0; c < 200; c++) begin
            vld[c] = ($urandom_range(0, 2) != 0); smp[c] = 4'($urandom_range(0, 15));
        end
        run_fill(1'b0, 5'd20, 0, "clamp");
    endtask

    task automatic test_abort();
        clear_stim();
        for (int c = 1; c < 40; c++) begin
            vld[c] = 1; smp[c] = 4'($urandom_range(0, 15));
        end
        abort_cyc = 32;
        run_fill(1'b0, 5'd8, 33, "abort");
        clear_stim();
        for (int c = 1; c < 12; c++) begin
            vld[c] = 1; smp[c] = 4'($urandom_range(0, 15));
        end
        run_fill(1'b0, 5'd1, 12, "abort_restart");
    endtask

    task automatic test_reset_midfill();
        clear_stim();
        for (int c = 0; c < 50; c++) begin
            vld[c] = 1; smp[c] = 4'($urandom_range(0, 15));
        end
        run_fill(1'b0, 5'd8, 43, "pre_reset");
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, fill_busy, fill_done, words_written} !== '0) begin
            failures++;
            $display("FAIL async_reset outputs got=%0b/%0h/%08h/%0b/%0b/%0d required=all zero",
                     mem_we, mem_addr, mem_wdata, fill_busy, fill_done, words_written);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        clear_stim();
        for (int c = 1; c < 12; c++) begin
            vld[c] = 1; smp[c] = 4'($urandom_range(0, 15));
        end
        run_fill(1'b0, 5'd1, 12, "post_reset");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            clear_stim();
            for (int c = 0; c < 40; c++) begin
                vld[c] = 1; smp[c] = 4'($urandom_range(0, 15));
            end
            run_fill(1'b0, 5'd2, 0, "back_to_back");
        end
    endtask

    task automatic test_random();
        logic tm;
        logic [AW:0] fw;
        for (int it = 0; it < 8; it++) begin
            clear_stim();
            tm = 1'($urandom_range(0, 1));
            fw = (AW + 1)'($urandom_range(1, 4));
            for (int c = 0; c < MAXC; c++) begin
                vld[c] = ($urandom_range(0, 3) != 0); smp[c] = 4'($urandom_range(0, 15));
            end
            trig_cyc = tm ? $urandom_range(1, 10) : -1;
            if ($urandom_range(0, 2) == 0) begin
                abort_cyc = $urandom_range(2, 20);
                run_fill(tm, fw, abort_cyc + 2, "random_abort");
            end else begin
                restart_cyc = 2;
                run_fill(tm, fw, 0, "random");
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_immediate();
        test_gapped();
        test_trigger();
        test_full_depth();
        test_abort();
        test_reset_midfill();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
